// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem handshake, IF/ID register with stall/redirect.
// Optional performance counters enabled by defining IF_PERF_CNT_EN.
module if_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  im_req,
  output logic [DATA_WIDTH-1:0] im_addr,
  input  logic                  im_ready,
  input  logic [DATA_WIDTH-1:0] im_rdata,
  input  logic                  im_rvalid,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  input  logic                  id_stall,
  output logic [DATA_WIDTH-1:0] id_instr,
  output logic [DATA_WIDTH-1:0] id_pc,
  output logic                  id_valid,
  output logic [31:0]           perf_fetch_cnt,
  output logic [31:0]           perf_drop_cnt
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP, S_HOLD} state_t;

  state_t                  state_reg, state_next;
  logic [DATA_WIDTH-1:0]   pc_reg, pc_next;
  logic [DATA_WIDTH-1:0]   id_instr_reg, id_instr_next;
  logic [DATA_WIDTH-1:0]   id_pc_reg, id_pc_next;
  logic                    id_valid_reg, id_valid_next;
  logic [DATA_WIDTH-1:0]   buf_instr_reg, buf_instr_next;
  logic [DATA_WIDTH-1:0]   buf_pc_reg, buf_pc_next;
  logic                    fetch_ok, fetch_drop;
  logic [DATA_WIDTH-1:0]   pc_plus4, redirect_aligned;

  assign pc_plus4         = pc_reg + DATA_WIDTH'(4);
  assign redirect_aligned = {redirect_pc[DATA_WIDTH-1:2], 2'b00};

  assign im_req   = (state_reg == S_REQ);
  assign im_addr  = pc_reg;
  assign id_instr = id_instr_reg;
  assign id_pc    = id_pc_reg;
  assign id_valid = id_valid_reg;

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    id_instr_next  = id_instr_reg;
    id_pc_next     = id_pc_reg;
    id_valid_next  = id_stall ? id_valid_reg : 1'b0;
    buf_instr_next = buf_instr_reg;
    buf_pc_next    = buf_pc_reg;
    fetch_ok       = 1'b0;
    fetch_drop     = 1'b0;

    if (redirect_valid) begin
      // Flush beats everything; an accepted-but-unreturned request must be drained in DROP.
      pc_next       = redirect_aligned;
      id_valid_next = 1'b0;
      id_instr_next = NOP_INSTR;
      case (state_reg)
        S_REQ:  state_next = im_ready ? S_DROP : S_REQ;
        S_WAIT, S_DROP: begin
          if (im_rvalid) begin
            state_next = S_REQ;
            fetch_drop = 1'b1;
          end else begin
            state_next = S_DROP;
          end
        end
        default: state_next = S_REQ;
      endcase
    end else begin
      case (state_reg)
        S_REQ: begin
          if (im_ready) state_next = S_WAIT;
        end
        S_WAIT: begin
          if (im_rvalid) begin
            fetch_ok = 1'b1;
            pc_next  = pc_plus4;
            if (!id_stall) begin
              id_instr_next = im_rdata;
              id_pc_next    = pc_reg;
              id_valid_next = 1'b1;
              state_next    = S_REQ;
            end else begin
              buf_instr_next = im_rdata;
              buf_pc_next    = pc_reg;
              state_next     = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          // The skid buffer is occupied exactly while in HOLD.
          if (!id_stall) begin
            id_instr_next = buf_instr_reg;
            id_pc_next    = buf_pc_reg;
            id_valid_next = 1'b1;
            state_next    = S_REQ;
          end
        end
        default: begin
          if (im_rvalid) begin
            fetch_drop = 1'b1;
            state_next = S_REQ;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= S_REQ;
      pc_reg        <= RESET_PC;
      id_instr_reg  <= NOP_INSTR;
      id_pc_reg     <= '0;
      id_valid_reg  <= 1'b0;
      buf_instr_reg <= NOP_INSTR;
      buf_pc_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      id_instr_reg  <= id_instr_next;
      id_pc_reg     <= id_pc_next;
      id_valid_reg  <= id_valid_next;
      buf_instr_reg <= buf_instr_next;
      buf_pc_reg    <= buf_pc_next;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_reg, drop_cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_reg <= '0;
      drop_cnt_reg  <= '0;
    end else begin
      if (fetch_ok)   fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
      if (fetch_drop) drop_cnt_reg  <= drop_cnt_reg + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_reg;
  assign perf_drop_cnt  = drop_cnt_reg;
`else
  logic unused_perf;
  assign unused_perf    = fetch_ok ^ fetch_drop;
  assign perf_fetch_cnt = '0;
  assign perf_drop_cnt  = '0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios, then random traffic against a
// transaction-level model (program-order stream, fetch address, response fate counts).
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ready;
  logic [31:0] im_rdata;
  logic        im_rvalid;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_stall;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_valid;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef IF_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  if_stage dut (
    .clk            (clk),
    .rst            (rst),
    .im_req         (im_req),
    .im_addr        (im_addr),
    .im_ready       (im_ready),
    .im_rdata       (im_rdata),
    .im_rvalid      (im_rvalid),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_stall       (id_stall),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_valid       (id_valid),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_drop_cnt  (perf_drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // Apply inputs for one cycle starting at a negedge; return at the following negedge.
  task automatic drive(input logic rdy, input logic rv, input logic [31:0] rd,
                       input logic st, input logic rdr, input logic [31:0] rp);
    im_ready       = rdy;
    im_rvalid      = rv;
    im_rdata       = rd;
    id_stall       = st;
    redirect_valid = rdr;
    redirect_pc    = rp;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    im_ready = 1'b0; im_rvalid = 1'b0; im_rdata = '0;
    id_stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  // Random-phase model state
  logic [31:0] exp_pc, next_fetch, out_addr;
  bit          outstanding, killed;
  int          resp_wait, consumed;
  int unsigned exp_fetch, exp_drop;
  logic        r_stall, r_redir, r_ready, r_rvalid, real_resp, accept;
  logic [31:0] r_rpc, r_rdata;

  initial begin
    // ---- Reset ----
    do_reset();
    check("rst_req",   {31'b0, im_req},   32'd1);
    check("rst_addr",  im_addr,           32'h0);
    check("rst_valid", {31'b0, id_valid}, 32'd0);
    check("rst_instr", id_instr,          32'h0000_0013);
    check("rst_pc",    id_pc,             32'h0);
    check("rst_pfetch", perf_fetch_cnt,   32'd0);
    check("rst_pdrop",  perf_drop_cnt,    32'd0);

    // ---- Straight-line fetch ----
    drive(1, 0, 0, 0, 0, 0);
    check("wait_noreq", {31'b0, im_req}, 32'd0);
    drive(0, 1, 32'h0050_0093, 0, 0, 0);
    check("sl_instr", id_instr, 32'h0050_0093);
    check("sl_pc",    id_pc,    32'h0);
    check("sl_valid", {31'b0, id_valid}, 32'd1);
    check("sl_req",   {31'b0, im_req},   32'd1);
    check("sl_addr",  im_addr, 32'h4);

    // ---- Stall on return ----
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 32'h0020_8133, 1, 0, 0);
    check("st_instr_hold", id_instr, 32'h0050_0093);
    check("st_pc_hold",    id_pc,    32'h0);
    check("st_noreq",      {31'b0, im_req}, 32'd0);
    drive(0, 0, 0, 0, 0, 0);
    check("st_rel_pc",    id_pc,    32'h4);
    check("st_rel_instr", id_instr, 32'h0020_8133);
    check("st_rel_valid", {31'b0, id_valid}, 32'd1);
    check("st_rel_addr",  im_addr,  32'h8);
    check("st_rel_req",   {31'b0, im_req}, 32'd1);

    // third good fetch
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 32'h0000_0013, 0, 0, 0);
    check("f3_pc", id_pc, 32'h8);

    // ---- Redirect while waiting ----
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 32'h0000_0100);
    check("rw_valid", {31'b0, id_valid}, 32'd0);
    check("rw_instr", id_instr, 32'h0000_0013);
    check("rw_noreq", {31'b0, im_req}, 32'd0);
    drive(0, 1, 32'hFFFF_FFFF, 0, 0, 0);
    check("rw_drop_valid", {31'b0, id_valid}, 32'd0);
    check("rw_req",  {31'b0, im_req}, 32'd1);
    check("rw_addr", im_addr, 32'h100);
    check("perf_fetch3", perf_fetch_cnt, PERF_EN ? 32'd3 : 32'd0);
    check("perf_drop1",  perf_drop_cnt,  PERF_EN ? 32'd1 : 32'd0);

    // ---- Redirect with same-cycle response ----
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 32'h1111_1111, 0, 1, 32'h0000_0203);
    check("rr_addr",  im_addr, 32'h200);
    check("rr_req",   {31'b0, im_req},   32'd1);
    check("rr_valid", {31'b0, id_valid}, 32'd0);
    check("perf_drop2", perf_drop_cnt, PERF_EN ? 32'd2 : 32'd0);

    // ---- Random traffic against the transaction model ----
    do_reset();
    exp_pc = 32'h0; next_fetch = 32'h0; out_addr = '0;
    outstanding = 0; killed = 0; resp_wait = 0; consumed = 0;
    exp_fetch = 0; exp_drop = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      check("r_pfetch", perf_fetch_cnt, PERF_EN ? exp_fetch : 32'd0);
      check("r_pdrop",  perf_drop_cnt,  PERF_EN ? exp_drop  : 32'd0);
      check("r_one_outstanding", {31'b0, im_req & outstanding}, 32'd0);
      if (im_req) check("r_fetch_addr", im_addr, next_fetch);

      r_stall = ($urandom_range(0, 3) == 0);
      r_redir = ($urandom_range(0, 15) == 0);
      r_rpc   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
      r_ready = ($urandom_range(0, 2) != 0);
      real_resp = outstanding && (resp_wait == 0);
      if (real_resp) begin
        r_rvalid = 1'b1; r_rdata = mem_word(out_addr);
      end else if (!outstanding && $urandom_range(0, 7) == 0) begin
        r_rvalid = 1'b1; r_rdata = 32'hDEAD_BEEF;
      end else begin
        r_rvalid = 1'b0; r_rdata = $urandom;
      end

      // Decode consumes IF/ID when valid and not stalled, unless flushed this cycle.
      if (id_valid && !r_stall && !r_redir) begin
        check("r_stream_pc",    id_pc,    exp_pc);
        check("r_stream_instr", id_instr, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end

      accept = im_req && r_ready;
      if (real_resp) begin
        if (killed || r_redir) exp_drop++;
        else                   exp_fetch++;
        outstanding = 0;
      end else if (outstanding) begin
        if (r_redir) killed = 1;
        resp_wait--;
      end
      if (accept) begin
        outstanding = 1;
        killed      = r_redir;
        out_addr    = im_addr;
        resp_wait   = $urandom_range(0, 3);
        next_fetch  = im_addr + 32'd4;
      end
      if (r_redir) begin
        exp_pc     = {r_rpc[31:2], 2'b00};
        next_fetch = {r_rpc[31:2], 2'b00};
      end

      drive(r_ready, r_rvalid, r_rdata, r_stall, r_redir, r_rpc);
    end
    check("r_final_pfetch", perf_fetch_cnt, PERF_EN ? exp_fetch : 32'd0);
    check("r_final_pdrop",  perf_drop_cnt,  PERF_EN ? exp_drop  : 32'd0);
    check("r_liveness", {31'b0, consumed >= 100}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
